// File: rtl/seg7_display_scheduler.sv
// Time-shares one 7-segment digit between the measured fan level and the setpoint,
// with a blinking edit view that preempts the alternation whenever the setpoint moves.
module seg7_display_scheduler #(
    parameter int unsigned TICK_DIV    = 1000,
    parameter int unsigned DWELL_TICKS = 8,
    parameter int unsigned BLINK_HALF  = 2,
    parameter int unsigned EDIT_TICKS  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] level_act,
    input  logic [3:0] level_set,
    output logic [3:0] digit,
    output logic       blank,
    output logic       dp,
    output logic [1:0] state
);

    localparam int unsigned PW = ($clog2(TICK_DIV) > 0) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW = ($clog2(DWELL_TICKS) > 0) ? $clog2(DWELL_TICKS) : 1;
    localparam int unsigned BW = ($clog2(BLINK_HALF) > 0) ? $clog2(BLINK_HALF) : 1;
    localparam int unsigned EW = ($clog2(EDIT_TICKS) > 0) ? $clog2(EDIT_TICKS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACT  = 2'd1;
    localparam logic [1:0] S_SET  = 2'd2;
    localparam logic [1:0] S_EDIT = 2'd3;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [EW-1:0] EDIT_LAST  = EW'(EDIT_TICKS - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [BW-1:0] blink_q, blink_d;
    logic [EW-1:0] edit_q, edit_d;
    logic          visible_q, visible_d;
    logic [3:0]    set_q;
    logic [1:0]    state_d;
    logic [3:0]    digit_d;
    logic          blank_d;
    logic          dp_d;
    logic          tick;
    logic          change;

    assign tick   = enable && (presc_q == PRESC_LAST);
    assign change = enable && (level_set != set_q);

    // State and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            presc_q   <= '0;
            dwell_q   <= '0;
            blink_q   <= '0;
            edit_q    <= '0;
            visible_q <= 1'b1;
            set_q     <= 4'd0;
            digit     <= 4'd0;
            blank     <= 1'b1;
            dp        <= 1'b0;
        end else begin
            state     <= state_d;
            presc_q   <= presc_d;
            dwell_q   <= dwell_d;
            blink_q   <= blink_d;
            edit_q    <= edit_d;
            visible_q <= visible_d;
            set_q     <= level_set;
            digit     <= digit_d;
            blank     <= blank_d;
            dp        <= dp_d;
        end
    end

    // Next state, counters and outputs; disable beats change beats expiry
    always_comb begin
        state_d   = state;
        dwell_d   = dwell_q;
        blink_d   = blink_q;
        edit_d    = edit_q;
        visible_d = visible_q;
        digit_d   = digit;
        blank_d   = 1'b1;
        dp_d      = 1'b0;

        if (!enable) begin
            presc_d = '0;
        end else if (tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end

        if (!enable) begin
            state_d   = S_IDLE;
            dwell_d   = '0;
            blink_d   = '0;
            edit_d    = '0;
            visible_d = 1'b1;
        end else if (change && (state != S_IDLE)) begin
            state_d   = S_EDIT;
            edit_d    = '0;
            blink_d   = '0;
            visible_d = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    state_d = S_ACT;
                    dwell_d = '0;
                end
                S_ACT, S_SET: begin
                    if (tick) begin
                        if (dwell_q == DWELL_LAST) begin
                            state_d = (state == S_ACT) ? S_SET : S_ACT;
                            dwell_d = '0;
                        end else begin
                            dwell_d = dwell_q + DW'(1);
                        end
                    end
                end
                default: begin
                    if (tick) begin
                        if (edit_q == EDIT_LAST) begin
                            state_d   = S_ACT;
                            dwell_d   = '0;
                            edit_d    = '0;
                            blink_d   = '0;
                            visible_d = 1'b1;
                        end else begin
                            edit_d = edit_q + EW'(1);
                            if (blink_q == BLINK_LAST) begin
                                blink_d   = '0;
                                visible_d = ~visible_q;
                            end else begin
                                blink_d = blink_q + BW'(1);
                            end
                        end
                    end
                end
            endcase
        end

        // Outputs follow the state being entered so they line up with it
        case (state_d)
            S_ACT: begin
                digit_d = level_act;
                blank_d = 1'b0;
            end
            S_SET: begin
                digit_d = level_set;
                blank_d = 1'b0;
                dp_d    = 1'b1;
            end
            S_EDIT: begin
                digit_d = level_set;
                blank_d = ~visible_d;
                dp_d    = 1'b1;
            end
            default: begin
                blank_d = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_seg7_display_scheduler.sv
// Directed bench for seg7_display_scheduler with TICK_DIV=4, DWELL_TICKS=3,
// BLINK_HALF=2, EDIT_TICKS=8 (one tick every 4 clk).
module tb_seg7_display_scheduler;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] level_act;
    logic [3:0] level_set;
    logic [3:0] digit;
    logic       blank;
    logic       dp;
    logic [1:0] state;

    int vectors;
    int miscompares;

    seg7_display_scheduler #(
        .TICK_DIV   (4),
        .DWELL_TICKS(3),
        .BLINK_HALF (2),
        .EDIT_TICKS (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .level_act(level_act),
        .level_set(level_set),
        .digit    (digit),
        .blank    (blank),
        .dp       (dp),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] s, input logic [3:0] d,
                           input logic b, input logic p);
        chk({tag, ".state"}, 8'(state), 8'(s));
        chk({tag, ".digit"}, 8'(digit), 8'(d));
        chk({tag, ".blank"}, 8'(blank), 8'(b));
        chk({tag, ".dp"},    8'(dp),    8'(p));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        enable      = 1'b1;
        level_act   = 4'd5;
        level_set   = 4'd9;
        #2;
        chk_all("reset", 2'd0, 4'd0, 1'b1, 1'b0);

        // 1: alternation ACT -> SET -> ACT, 12 clk each
        @(negedge clk);
        reset = 1'b0;
        step(1);                                   // E1
        chk_all("first_act", 2'd1, 4'd5, 1'b0, 1'b0);
        step(10);                                  // E11
        chk("act_before_dwell", 8'(state), 8'd1);
        step(1);                                   // E12
        chk_all("first_set", 2'd2, 4'd9, 1'b0, 1'b1);
        step(12);                                  // E24
        chk_all("back_to_act", 2'd1, 4'd5, 1'b0, 1'b0);

        // 2: level_act tracking without disturbing dwell
        level_act = 4'd7;
        step(1);                                   // E25
        chk_all("act_track", 2'd1, 4'd7, 1'b0, 1'b0);
        step(10);                                  // E35
        chk("dwell_kept_act", 8'(state), 8'd1);
        step(1);                                   // E36
        chk("dwell_kept_set", 8'(state), 8'd2);
        step(12);                                  // E48
        chk("act_again", 8'(state), 8'd1);

        // 3: setpoint change on a tick edge enters EDIT and blinks
        step(3);                                   // E51
        level_set = 4'd10;
        step(1);                                   // E52
        chk_all("edit_enter", 2'd3, 4'd10, 1'b0, 1'b1);
        step(7);                                   // E59
        chk("blink_vis_7", 8'(blank), 8'd0);
        step(1);                                   // E60
        chk("blink_off_8", 8'(blank), 8'd1);
        step(8);                                   // E68
        chk("blink_on_16", 8'(blank), 8'd0);
        step(15);                                  // E83
        chk("edit_hold_31", 8'(state), 8'd3);
        step(1);                                   // E84
        chk_all("edit_exit_32", 2'd1, 4'd7, 1'b0, 1'b0);

        // 4: change coincides with dwell expiry, then restart of edit window
        step(11);                                  // E95
        level_set = 4'd3;
        step(1);                                   // E96
        chk_all("change_beats_expiry", 2'd3, 4'd3, 1'b0, 1'b1);
        step(19);                                  // E115
        level_set = 4'd4;
        step(1);                                   // E116
        chk_all("edit_restart", 2'd3, 4'd4, 1'b0, 1'b1);
        step(4);                                   // E120
        chk("restart_blink_4", 8'(blank), 8'd0);
        step(4);                                   // E124
        chk("restart_blink_8", 8'(blank), 8'd1);
        step(4);                                   // E128
        chk("restart_no_early_exit", 8'(state), 8'd3);
        step(19);                                  // E147
        chk("restart_hold_31", 8'(state), 8'd3);
        step(1);                                   // E148
        chk_all("restart_exit_32", 2'd1, 4'd7, 1'b0, 1'b0);

        // 5: disable in SET, setpoint moves while parked, re-enable to ACT
        step(12);                                  // E160
        chk("set_before_disable", 8'(state), 8'd2);
        enable = 1'b0;
        step(1);
        chk_all("disabled", 2'd0, 4'd4, 1'b1, 1'b0);
        level_set = 4'd6;
        step(3);
        chk_all("disabled_hold", 2'd0, 4'd4, 1'b1, 1'b0);
        enable = 1'b1;
        step(1);                                   // R1
        chk_all("reenable_act", 2'd1, 4'd7, 1'b0, 1'b0);
        step(10);                                  // R11
        chk("reenable_dwell_11", 8'(state), 8'd1);
        step(1);                                   // R12
        chk_all("reenable_set_12", 2'd2, 4'd6, 1'b0, 1'b1);

        // 6: async reset between edges while in EDIT
        level_set = 4'd2;
        step(1);
        chk("edit_before_reset", 8'(state), 8'd3);
        step(2);
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_reset", 2'd0, 4'd0, 1'b1, 1'b0);
        step(1);
        chk_all("reset_held", 2'd0, 4'd0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg7_display_scheduler.md
Name: seg7_display_scheduler

Overview:
Time-shares the single 7-segment digit between two 4-bit fan quantities: the measured fan level and the user setpoint.
- Drives the nibble, blank and decimal-point inputs of the existing hex-to-segment decoder.
- Alternates the two sources on a slow tick.
- Preempts the alternation with a blinking "edit" view whenever the setpoint changes.
- Sits between the fan-control core and the segment decoder at the top level.

Parameters:
- TICK_DIV, 1000: clk cycles per scheduler tick (must be >= 2).
- DWELL_TICKS, 8: ticks each source is shown in normal alternation (>= 1).
- BLINK_HALF, 2: ticks per blink half-period in EDIT (>= 1).
- EDIT_TICKS, 16: ticks without a setpoint change before EDIT exits (>= 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  display enable; 0 blanks the display and parks the scheduler.
- level_act  in  4  measured fan level.
- level_set  in  4  fan setpoint.
- digit  out  4  nibble to the segment decoder.
- blank  out  1  1 = segments forced off downstream.
- dp  out  1  decimal point; 1 = the setpoint is being shown.
- state  out  2  current state for debug: 0 IDLE, 1 ACT, 2 SET, 3 EDIT.

Behaviour:
- Reset (async, active-high) values:
  - state = IDLE, digit = 0, blank = 1, dp = 0.
  - Prescaler, dwell, blink and edit counters = 0; blink phase = visible; set_q = 0.
- All outputs are registered. A change in state or input appears on the outputs one clk after the edge that causes it.
- Prescaler:
  - Counts 0..TICK_DIV-1 while enable = 1, then wraps to 0.
  - tick = (prescaler == TICK_DIV-1), one clk wide.
  - Cleared while enable = 0.
  - Counter widths use $clog2 of the respective parameter.
- set_q samples level_set every clk, including while disabled.
- change = (level_set != set_q), evaluated only when enable = 1.
- State IDLE:
  - Outputs: blank = 1, dp = 0, digit holds its last value.
  - enable = 1 -> ACT with dwell counter = 0.
- State ACT:
  - Outputs: digit = level_act (tracked every clk), blank = 0, dp = 0.
  - Dwell counter increments on each tick.
  - On the tick at which dwell reaches DWELL_TICKS-1 -> SET, dwell counter = 0.
- State SET:
  - Outputs: digit = level_set, blank = 0, dp = 1.
  - Same dwell rule as ACT; on expiry -> ACT.
- State EDIT:
  - Outputs: digit = level_set, dp = 1, blank = inverse of blink phase.
  - Blink phase toggles every BLINK_HALF ticks and starts visible.
  - Edit counter increments on each tick.
  - On the tick at which it reaches EDIT_TICKS-1 -> ACT with dwell = 0, blink phase = visible.
- change in ACT, SET or EDIT:
  - -> EDIT (or stay in EDIT).
  - Edit counter = 0, blink counter = 0, blink phase = visible.
- Priority, highest first: enable = 0, then change, then counter expiry. A change on the same clk as a dwell or edit expiry wins; no ACT/SET step occurs.
- enable = 0 in any state:
  - Next clk: IDLE, blank = 1, dp = 0.
  - All counters cleared; prescaler restarts from 0 on re-enable.
  - Re-enable always resumes at ACT, never EDIT, even if level_set changed while disabled.
- Reset asserted mid-operation forces the reset values immediately, independent of clk.

Test Plan:
Bench parameters: TICK_DIV = 4, DWELL_TICKS = 3, BLINK_HALF = 2, EDIT_TICKS = 8.
1. Release reset with enable = 1, level_act = 5, level_set = 9 -> one clk later state = ACT, digit = 5, dp = 0, blank = 0. After 12 clk: state = SET, digit = 9, dp = 1. After 12 more clk: back to ACT.
2. In ACT, change level_act 5 -> 7 -> digit = 7 on the next clk. state remains ACT and the dwell count is unaffected.
3. In ACT, change level_set 9 -> 10 -> next clk: state = EDIT, digit = 10, dp = 1, blank = 0. blank toggles every 8 clk (1 after 8, 0 after 16). Returns to ACT 32 clk after the change with blank = 0.
4. Change level_set on the exact clk at which the dwell expires in ACT -> state = EDIT, never SET. A second change 20 clk into EDIT restarts the 32-clk edit window with blank = 0.
5. Drop enable in SET -> next clk: state = IDLE, blank = 1, dp = 0. Change level_set while disabled, then raise enable -> state = ACT (not EDIT) and the first tick occurs 4 clk after re-enable.
6. Assert reset asynchronously between clk edges while in EDIT -> outputs show digit = 0, blank = 1, dp = 0, state = 0 before the next clk edge.
